// File: rtl/cla_pipe_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
interface cla_pipe_if #(
   parameter int unsigned WIDTH = 32
);
   logic             VALID_in;
   logic             READY_out;
   logic [WIDTH-1:0] A_in;
   logic [WIDTH-1:0] B_in;
   logic             C_in;
   logic             SUB_in;
   logic [WIDTH-1:0] S_out;
   logic             C_out;
   logic             OVF_out;
   logic             VALID_out;
   logic             READY_in;

   modport master (
      output VALID_in, A_in, B_in, C_in, SUB_in, READY_in,
      input  READY_out, S_out, C_out, OVF_out, VALID_out
   );

   modport slave (
      input  VALID_in, A_in, B_in, C_in, SUB_in, READY_in,
      output READY_out, S_out, C_out, OVF_out, VALID_out
   );
endinterface

// File: rtl/cla_pipe.sv
// Pipelined adder/subtractor: one slice of 4-bit CLA groups per stage, operands skewed in
// and sums deskewed out so each result leaves in one beat.
module cla_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input logic       CLK_in,
   input logic       RSTn_in,
   cla_pipe_if.slave bus
);
   localparam int unsigned SW = WIDTH / STAGES;
   localparam int unsigned NG = SW / 4;

   // Returns {carry into slice MSB, carry out of slice, slice sum}.
   function automatic logic [SW+1:0] cla_slice(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                                input logic cin);
      logic [SW-1:0] g, p;
      logic [NG-1:0] gg, gp;
      logic [NG:0]   gc;
      logic [SW:0]   c;
      logic          t;
      g = a & b;
      p = a ^ b;
      for (int n = 0; n < NG; n++) begin
         gg[n] = g[4*n+3] | (p[4*n+3] & g[4*n+2]) | (p[4*n+3] & p[4*n+2] & g[4*n+1])
               | (p[4*n+3] & p[4*n+2] & p[4*n+1] & g[4*n]);
         gp[n] = &p[4*n +: 4];
      end
      // Flat sum-of-products lookahead across groups; t is the running propagate product.
      gc[0] = cin;
      for (int n = 1; n <= NG; n++) begin
         gc[n] = 1'b0;
         t     = 1'b1;
         for (int j = n - 1; j >= 0; j--) begin
            gc[n] = gc[n] | (t & gg[j]);
            t     = t & gp[j];
         end
         gc[n] = gc[n] | (t & cin);
      end
      for (int n = 0; n < NG; n++) begin
         c[4*n]   = gc[n];
         c[4*n+1] = g[4*n] | (p[4*n] & gc[n]);
         c[4*n+2] = g[4*n+1] | (p[4*n+1] & g[4*n]) | (p[4*n+1] & p[4*n] & gc[n]);
         c[4*n+3] = g[4*n+2] | (p[4*n+2] & g[4*n+1]) | (p[4*n+2] & p[4*n+1] & g[4*n])
                  | (p[4*n+2] & p[4*n+1] & p[4*n] & gc[n]);
      end
      c[SW] = gc[NG];
      return {c[SW-1], c[SW], p ^ c[SW-1:0]};
   endfunction

   logic [STAGES-1:0]             valid_q, carry_q;
   logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, sum_q;
   logic                          ovf_q;

   logic [STAGES-1:0]             in_v, in_c;
   logic [STAGES-1:0][WIDTH-1:0]  in_a, in_b, in_sum, nxt_sum;
   logic [STAGES-1:0][SW+1:0]     res;
   logic                          advance;

   assign advance = ~valid_q[STAGES-1] | bus.READY_in;

   always_comb begin
      in_v   = '0;
      in_c   = '0;
      in_a   = '0;
      in_b   = '0;
      in_sum = '0;
      // Subtraction folds into the adder as A + ~B + ~borrow.
      in_v[0] = bus.VALID_in;
      in_a[0] = bus.A_in;
      in_b[0] = bus.SUB_in ? ~bus.B_in : bus.B_in;
      in_c[0] = bus.C_in ^ bus.SUB_in;
      for (int k = 1; k < STAGES; k++) begin
         in_v[k]   = valid_q[k-1];
         in_a[k]   = a_q[k-1];
         in_b[k]   = b_q[k-1];
         in_c[k]   = carry_q[k-1];
         in_sum[k] = sum_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         res[k]                 = cla_slice(in_a[k][k*SW +: SW], in_b[k][k*SW +: SW], in_c[k]);
         nxt_sum[k]             = in_sum[k];
         nxt_sum[k][k*SW +: SW] = res[k][SW-1:0];
      end
   end

   // Invalid slots carry zeroed results so the output reads 0 whenever VALID_out is low.
   always_ff @(posedge CLK_in or negedge RSTn_in) begin
      if (!RSTn_in) begin
         valid_q <= '0;
         carry_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (advance) begin
         valid_q <= in_v;
         a_q     <= in_a;
         b_q     <= in_b;
         for (int k = 0; k < STAGES; k++) begin
            sum_q[k]   <= in_v[k] ? nxt_sum[k] : '0;
            carry_q[k] <= in_v[k] & res[k][SW];
         end
         ovf_q <= in_v[STAGES-1] & (res[STAGES-1][SW+1] ^ res[STAGES-1][SW]);
      end
   end

   assign bus.READY_out = advance;
   assign bus.VALID_out = valid_q[STAGES-1];
   assign bus.S_out     = sum_q[STAGES-1];
   assign bus.C_out     = carry_q[STAGES-1];
   assign bus.OVF_out   = ovf_q;

   // Last-stage operand copies and intermediate MSB carries have no reader.
   logic unused_bits;
   assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], res};
endmodule
